// File: rtl/alu_accumulator_pkg.sv
// Shared ALU encodings: instruction classes, op codes, MOV codes, operand
// select bit and flag bit positions. The instruction-cycle FSM uses them too.
package alu_accumulator_pkg;

  localparam int unsigned FLAG_W     = 4;
  localparam int unsigned FLAG_ZERO  = 0;
  localparam int unsigned FLAG_CARRY = 1;
  localparam int unsigned FLAG_NEG   = 2;
  localparam int unsigned FLAG_OV    = 3;

  // IR bit choosing operand 2: 0 = IBR (immediate), 1 = MBR (memory)
  localparam int unsigned OPSEL_BIT  = 0;

  typedef enum logic [1:0] {
    CLS_MOV   = 2'b00,
    CLS_ARITH = 2'b01,
    CLS_LOGIC = 2'b10,
    CLS_RSVD  = 2'b11
  } alu_class_e;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_ADC  = 4'h1,
    OP_SUB  = 4'h2,
    OP_SBB  = 4'h3,
    OP_INC  = 4'h4,
    OP_DEC  = 4'h5,
    OP_CMP  = 4'h6,
    OP_MUL  = 4'h7,
    OP_MOVH = 4'h8
  } arith_op_e;

  typedef enum logic [3:0] {
    OP_AND = 4'h0,
    OP_OR  = 4'h1,
    OP_XOR = 4'h2,
    OP_NOT = 4'h3,
    OP_SHL = 4'h4,
    OP_SHR = 4'h5,
    OP_ROL = 4'h6,
    OP_ROR = 4'h7
  } logic_op_e;

  typedef enum logic [5:0] {
    MOV_NOP     = 6'h00,
    MOV_LOAD_I  = 6'h01,
    MOV_LOAD_X  = 6'h02,
    MOV_STORE_X = 6'h03,
    MOV_STORE_I = 6'h04,
    MOV_JMP     = 6'h08,
    MOV_JZ      = 6'h09,
    MOV_JC      = 6'h0A,
    MOV_JN      = 6'h0B,
    MOV_JV      = 6'h0C
  } mov_op_e;

endpackage

// File: rtl/alu_accumulator_core.sv
// Combinational ALU: result, HR and next flags from class/code and operands.
// Optional multiplier enabled by defining ALU_MUL_EN.
module alu_core
  import alu_accumulator_pkg::*;
#(
  parameter int unsigned DW = 8
) (
  input  logic [1:0]        cls,
  input  logic [5:0]        code,
  input  logic [DW-1:0]     a,
  input  logic [DW-1:0]     ibr,
  input  logic [DW-1:0]     mbr,
  input  logic [DW-1:0]     hr,
  input  logic [FLAG_W-1:0] flags,
  output logic [DW-1:0]     result_c,
  output logic [DW-1:0]     hr_c,
  output logic [FLAG_W-1:0] flags_c,
  output logic              ar_we_c,
  output logic              hr_we_c,
  output logic              illegal_c
);

  localparam int unsigned MSB = DW - 1;

  logic [DW-1:0] b_sel;
  logic [DW-1:0] opb;
  logic [DW:0]   sum;
  logic          add_op;
  logic          sub_op;
  logic          use_cin;
  logic          upd_zn;
  logic          logic_cls;
  logic          lcarry;

  assign b_sel = code[OPSEL_BIT] ? mbr : ibr;

`ifdef ALU_MUL_EN
  logic [2*DW-1:0] prod;
  assign prod = (2*DW)'(a) * (2*DW)'(b_sel);
`endif

  // Decode and compute; add/sub share one adder, Z/N derived at the end
  always_comb begin
    result_c  = a;
    hr_c      = hr;
    flags_c   = flags;
    ar_we_c   = 1'b0;
    hr_we_c   = 1'b0;
    illegal_c = 1'b0;
    opb       = b_sel;
    add_op    = 1'b0;
    sub_op    = 1'b0;
    use_cin   = 1'b0;
    upd_zn    = 1'b0;
    logic_cls = 1'b0;
    lcarry    = 1'b0;
    sum       = '0;

    case (alu_class_e'(cls))
      CLS_MOV: begin
        case (mov_op_e'(code))
          MOV_NOP, MOV_STORE_X, MOV_STORE_I,
          MOV_JMP, MOV_JZ, MOV_JC, MOV_JN, MOV_JV: ;
          MOV_LOAD_I: begin result_c = ibr; ar_we_c = 1'b1; upd_zn = 1'b1; end
          MOV_LOAD_X: begin result_c = mbr; ar_we_c = 1'b1; upd_zn = 1'b1; end
          default:    illegal_c = 1'b1;
        endcase
      end
      CLS_ARITH: begin
        case (arith_op_e'(code[5:2]))
          OP_ADD: begin add_op = 1'b1; ar_we_c = 1'b1; end
          OP_ADC: begin add_op = 1'b1; use_cin = 1'b1; ar_we_c = 1'b1; end
          OP_SUB: begin sub_op = 1'b1; ar_we_c = 1'b1; end
          OP_SBB: begin sub_op = 1'b1; use_cin = 1'b1; ar_we_c = 1'b1; end
          OP_INC: begin add_op = 1'b1; opb = DW'(1); ar_we_c = 1'b1; end
          OP_DEC: begin sub_op = 1'b1; opb = DW'(1); ar_we_c = 1'b1; end
          OP_CMP: sub_op = 1'b1;
`ifdef ALU_MUL_EN
          OP_MUL: begin
            result_c          = prod[DW-1:0];
            hr_c              = prod[2*DW-1:DW];
            ar_we_c           = 1'b1;
            hr_we_c           = 1'b1;
            upd_zn            = 1'b1;
            flags_c[FLAG_CARRY] = |prod[2*DW-1:DW];
            flags_c[FLAG_OV]    = 1'b0;
          end
`endif
          OP_MOVH: begin result_c = hr; ar_we_c = 1'b1; upd_zn = 1'b1; end
          default: illegal_c = 1'b1;
        endcase
      end
      CLS_LOGIC: begin
        logic_cls = 1'b1;
        case (logic_op_e'(code[5:2]))
          OP_AND: result_c = a & b_sel;
          OP_OR:  result_c = a | b_sel;
          OP_XOR: result_c = a ^ b_sel;
          OP_NOT: result_c = ~a;
          OP_SHL: begin result_c = {a[MSB-1:0], 1'b0}; lcarry = a[MSB]; end
          OP_SHR: begin result_c = {1'b0, a[MSB:1]};   lcarry = a[0];   end
          OP_ROL: begin result_c = {a[MSB-1:0], a[MSB]}; lcarry = a[MSB]; end
          OP_ROR: begin result_c = {a[0], a[MSB:1]};     lcarry = a[0];   end
          default: begin logic_cls = 1'b0; illegal_c = 1'b1; end
        endcase
      end
      default: illegal_c = 1'b1;
    endcase

    if (logic_cls) begin
      ar_we_c             = 1'b1;
      upd_zn              = 1'b1;
      flags_c[FLAG_CARRY] = lcarry;
      flags_c[FLAG_OV]    = 1'b0;
    end

    // Carry out of bit DW is carry for add and borrow for subtract
    if (add_op || sub_op) begin
      if (add_op) begin
        sum = {1'b0, a} + {1'b0, opb} + (DW+1)'(use_cin & flags[FLAG_CARRY]);
        flags_c[FLAG_OV] = (a[MSB] == opb[MSB]) && (sum[MSB] != a[MSB]);
      end else begin
        sum = {1'b0, a} - {1'b0, opb} - (DW+1)'(use_cin & flags[FLAG_CARRY]);
        flags_c[FLAG_OV] = (a[MSB] != opb[MSB]) && (sum[MSB] != a[MSB]);
      end
      result_c            = sum[DW-1:0];
      flags_c[FLAG_CARRY] = sum[DW];
      upd_zn              = 1'b1;
    end

    if (upd_zn) begin
      flags_c[FLAG_ZERO] = (result_c == '0);
      flags_c[FLAG_NEG]  = result_c[MSB];
    end
  end

endmodule

// File: rtl/alu_accumulator.sv
// Accumulator/flags/HR registers with Exec gating and sticky ill_op.
// Define ALU_MUL_EN to enable the MUL op (otherwise MUL is illegal, HR stays 0).
module alu_accumulator
  import alu_accumulator_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned INST_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  Exec,
  input  logic [INST_WIDTH-1:0] IR,
  input  logic [INST_WIDTH-1:0] IBR,
  input  logic [DATA_WIDTH-1:0] MBR,
  output logic [DATA_WIDTH-1:0] AR,
  output logic [FLAG_W-1:0]     Flags,
  output logic                  ill_op
);

  logic [DATA_WIDTH-1:0] hr_q;
  logic [DATA_WIDTH-1:0] result_c;
  logic [DATA_WIDTH-1:0] hr_c;
  logic [FLAG_W-1:0]     flags_c;
  logic                  ar_we_c;
  logic                  hr_we_c;
  logic                  illegal_c;

  alu_core #(
    .DW (DATA_WIDTH)
  ) u_core (
    .cls       (IR[7:6]),
    .code      (IR[5:0]),
    .a         (AR),
    .ibr       (DATA_WIDTH'(IBR)),
    .mbr       (MBR),
    .hr        (hr_q),
    .flags     (Flags),
    .result_c  (result_c),
    .hr_c      (hr_c),
    .flags_c   (flags_c),
    .ar_we_c   (ar_we_c),
    .hr_we_c   (hr_we_c),
    .illegal_c (illegal_c)
  );

  // Commit the decoded operation on an Exec strobe; reset dominates
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      AR     <= '0;
      Flags  <= '0;
      hr_q   <= '0;
      ill_op <= 1'b0;
    end else if (Exec) begin
      if (ar_we_c) AR <= result_c;
      if (hr_we_c) hr_q <= hr_c;
      if (illegal_c) ill_op <= 1'b1;
      Flags <= flags_c;
    end
  end

endmodule

// File: tb/tb_alu_accumulator.sv
// Scoreboard bench for alu_accumulator: stimulus pushes model predictions,
// a monitor pops them one cycle after each Exec and checks holds otherwise.
module tb_alu_accumulator;

  logic       clk;
  logic       arst;
  logic       Exec;
  logic [7:0] IR, IBR, MBR;
  logic [7:0] AR;
  logic [3:0] Flags;
  logic       ill_op;

  alu_accumulator dut (
    .clk    (clk),
    .arst   (arst),
    .Exec   (Exec),
    .IR     (IR),
    .IBR    (IBR),
    .MBR    (MBR),
    .AR     (AR),
    .Flags  (Flags),
    .ill_op (ill_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] ar;
    logic [3:0] fl;
    logic       ill;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic saw_exec;

  // Reference state
  logic [7:0] m_ar, m_hr;
  bit         m_z, m_c, m_n, m_v, m_ill;

  task automatic check(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic expect_state(input string name, input logic [7:0] ar,
                              input logic [3:0] fl, input logic ill);
    check({name, "_AR"}, int'(AR), int'(ar));
    check({name, "_Flags"}, int'(Flags), int'(fl));
    check({name, "_ill"}, int'(ill_op), int'(ill));
  endtask

  function automatic exp_t model_state();
    exp_t e;
    e.ar  = m_ar;
    e.fl  = {m_v, m_n, m_c, m_z};
    e.ill = m_ill;
    return e;
  endfunction

  function automatic void model_reset();
    m_ar = 8'h00; m_hr = 8'h00;
    m_z = 0; m_c = 0; m_n = 0; m_v = 0; m_ill = 0;
  endfunction

  // Behavioural model using plain integer arithmetic
  function automatic void model_exec(input logic [7:0] ir, input logic [7:0] ibr,
                                     input logic [7:0] mbr);
    int a, b, c, r, sa, sb, sr, p;
    bit wr, zn, cv, ill, cf, vf;
    a  = int'(m_ar);
    b  = ir[0] ? int'(mbr) : int'(ibr);
    c  = m_c ? 1 : 0;
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    r = a; sr = 0; wr = 0; zn = 0; cv = 0; ill = 0; cf = 0; vf = 0;
    case (ir[7:6])
      2'd0: case (ir[5:0])
        6'd0, 6'd3, 6'd4, 6'd8, 6'd9, 6'd10, 6'd11, 6'd12: ;
        6'd1: begin r = int'(ibr); wr = 1; zn = 1; end
        6'd2: begin r = int'(mbr); wr = 1; zn = 1; end
        default: ill = 1;
      endcase
      2'd1: begin
        wr = 1; zn = 1; cv = 1;
        case (ir[5:2])
          4'd0: begin r = a + b;     sr = sa + sb;     cf = (r > 255); end
          4'd1: begin r = a + b + c; sr = sa + sb + c; cf = (r > 255); end
          4'd2: begin r = a - b;     sr = sa - sb;     cf = (a < b); end
          4'd3: begin r = a - b - c; sr = sa - sb - c; cf = (a < b + c); end
          4'd4: begin r = a + 1;     sr = sa + 1;      cf = (r > 255); end
          4'd5: begin r = a - 1;     sr = sa - 1;      cf = (a < 1); end
          4'd6: begin r = a - b;     sr = sa - sb;     cf = (a < b); wr = 0; end
`ifdef ALU_MUL_EN
          4'd7: begin p = a * b; r = p % 256; m_hr = 8'(p / 256); cf = (p >= 256); end
`endif
          4'd8: begin r = int'(m_hr); cv = 0; end
          default: ill = 1;
        endcase
        vf = (sr > 127) || (sr < -128);
      end
      2'd2: begin
        wr = 1; zn = 1; cv = 1;
        case (ir[5:2])
          4'd0: r = a & b;
          4'd1: r = a | b;
          4'd2: r = a ^ b;
          4'd3: r = 255 - a;
          4'd4: begin r = (a * 2) % 256;           cf = (a >= 128); end
          4'd5: begin r = a / 2;                   cf = (a % 2 == 1); end
          4'd6: begin r = (a * 2) % 256 + a / 128; cf = (a >= 128); end
          4'd7: begin r = a / 2 + (a % 2) * 128;   cf = (a % 2 == 1); end
          default: ill = 1;
        endcase
      end
      default: ill = 1;
    endcase
    if (ill) begin
      m_ill = 1;
    end else begin
      r = r & 255;
      if (wr) m_ar = 8'(r);
      if (zn) begin m_z = (r == 0); m_n = (r >= 128); end
      if (cv) begin m_c = cf; m_v = vf; end
    end
  endfunction

  task automatic junk_inputs();
    IR  = 8'($urandom);
    IBR = 8'($urandom);
    MBR = 8'($urandom);
  endtask

  // One Exec strobe, then three cycles of Exec=0 with changing inputs
  task automatic exec_op(input logic [7:0] ir, input logic [7:0] ibr, input logic [7:0] mbr);
    @(posedge clk); #1;
    IR = ir; IBR = ibr; MBR = mbr; Exec = 1'b1;
    model_exec(ir, ibr, mbr);
    exp_q.push_back(model_state());
    @(posedge clk); #1;
    Exec = 1'b0;
    junk_inputs();
    repeat (2) begin @(posedge clk); #1; junk_inputs(); end
  endtask

  // Reset asserted mid-cycle while an Exec is presented
  task automatic do_reset();
    @(posedge clk); #1;
    IR = 8'h01; IBR = 8'hA5; Exec = 1'b1;
    #2 arst = 1'b1;
    #1 expect_state("reset_async", 8'h00, 4'h0, 1'b0);
    @(posedge clk); #1;
    expect_state("reset_edge", 8'h00, 4'h0, 1'b0);
    Exec = 1'b0;
    arst = 1'b0;
    exp_q.delete();
    model_reset();
  endtask

  function automatic logic [7:0] rand_ir();
    logic [7:0] ir;
    int sel;
    sel = $urandom_range(0, 9);
    ir  = 8'($urandom);
    case (sel)
      0, 1: ir = {2'b00, 6'($urandom_range(0, 13))};
      2, 3, 4, 5: ir = {2'b01, 4'($urandom_range(0, 9)), 2'($urandom)};
      6, 7, 8: ir = {2'b10, 4'($urandom_range(0, 8)), 2'($urandom)};
      default: ;
    endcase
    return ir;
  endfunction

  // Sample Exec at the same edge the DUT does
  initial begin
    saw_exec = 1'b0;
    forever begin
      @(posedge clk);
      saw_exec = Exec && !arst;
    end
  end

  // Monitor: pop on a committed Exec, otherwise outputs must hold
  initial begin
    exp_t last, e;
    last = '0;
    forever begin
      @(negedge clk);
      if (arst) begin
        last = '0;
      end else if (saw_exec) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL scoreboard_empty: got an Exec result, expected queue empty (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          check("exec_AR", int'(AR), int'(e.ar));
          check("exec_Flags", int'(Flags), int'(e.fl));
          check("exec_ill", int'(ill_op), int'(e.ill));
          last = e;
        end
      end else begin
        check("hold_AR", int'(AR), int'(last.ar));
        check("hold_Flags", int'(Flags), int'(last.fl));
        check("hold_ill", int'(ill_op), int'(last.ill));
      end
    end
  end

  initial begin
    arst = 1'b1; Exec = 1'b0; IR = 8'h00; IBR = 8'h00; MBR = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1 arst = 1'b0;

    // LOAD_I 0x7F, ADD #1: signed overflow into 0x80
    exec_op(8'h01, 8'h7F, 8'h00);
    exec_op(8'h40, 8'h01, 8'h00);
    expect_state("add_ovf", 8'h80, 4'hC, 1'b0);

    // LOAD_X 5, SUB mem 6, CMP #0xFF
    exec_op(8'h02, 8'h00, 8'h05);
    exec_op(8'h49, 8'h00, 8'h06);
    expect_state("sub_borrow", 8'hFF, 4'h6, 1'b0);
    exec_op(8'h58, 8'hFF, 8'h00);
    expect_state("cmp_eq", 8'hFF, 4'h1, 1'b0);

    // LOAD_I 0x81, ROL, SHR, AND #0
    exec_op(8'h01, 8'h81, 8'h00);
    exec_op(8'h98, 8'h00, 8'h00);
    expect_state("rol", 8'h03, 4'h2, 1'b0);
    exec_op(8'h94, 8'h00, 8'h00);
    expect_state("shr", 8'h01, 4'h2, 1'b0);
    exec_op(8'h80, 8'h00, 8'h00);
    expect_state("and0", 8'h00, 4'h1, 1'b0);

    // Ten idle cycles with changing inputs, then a class-11 Exec
    repeat (10) begin @(posedge clk); #1; junk_inputs(); end
    expect_state("idle", 8'h00, 4'h1, 1'b0);
    exec_op(8'hC0, 8'h12, 8'h34);
    expect_state("class11", 8'h00, 4'h1, 1'b1);

    // Wrap-around 0xFF + 1 via INC
    do_reset();
    exec_op(8'h01, 8'hFF, 8'h00);
    exec_op(8'h50, 8'h00, 8'h00);
    expect_state("inc_wrap", 8'h00, 4'h3, 1'b0);

    // MUL 0x10 * 0x20 then MOVH
    do_reset();
    exec_op(8'h01, 8'h10, 8'h00);
    exec_op(8'h5C, 8'h20, 8'h00);
`ifdef ALU_MUL_EN
    expect_state("mul", 8'h00, 4'h3, 1'b0);
    exec_op(8'h60, 8'h00, 8'h00);
    expect_state("movh", 8'h02, 4'h2, 1'b0);
`else
    expect_state("mul_ill", 8'h10, 4'h0, 1'b1);
    exec_op(8'h60, 8'h00, 8'h00);
    expect_state("movh", 8'h00, 4'h1, 1'b1);
`endif

    // Randomized operations with periodic resets
    for (int i = 0; i < 150; i++) begin
      if (i % 50 == 0) do_reset();
      exec_op(rand_ir(), 8'($urandom), 8'($urandom));
    end

    repeat (2) @(posedge clk);
    #1 check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
